// File: rtl/obstacle_pkg.sv
// obstacle_pkg: shared types for the obstacle field and its candidate checker.
package obstacle_pkg;
  localparam int COORD_MAX_W = 8;
  typedef logic [COORD_MAX_W-1:0] coord_t;
  typedef enum logic [1:0] {IDLE, CAPTURE, SCAN, COMMIT} state_t;
  typedef struct packed {
    logic   valid;
    coord_t x;
    coord_t y;
  } obs_slot_t;
endpackage

// File: rtl/obstacle_candidate_check.sv
// obstacle_candidate_check: single-cycle static rejection of a candidate cell.
module obstacle_candidate_check
  import obstacle_pkg::*;
#(
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 16,
  parameter int MAX_OBS = 8
) (
  input  coord_t    cand_x,
  input  coord_t    cand_y,
  input  coord_t    apple_x,
  input  coord_t    apple_y,
  input  coord_t    head_x,
  input  coord_t    head_y,
  input  logic      head_valid,
  input  obs_slot_t slots [MAX_OBS],
  output logic      hit
);
  logic border, apple, near, slot;
  always_comb begin
    border = cand_x == '0 || cand_x == coord_t'(GRID_W - 1) ||
             cand_y == '0 || cand_y == coord_t'(GRID_H - 1);
    apple  = cand_x == apple_x && cand_y == apple_y;
    // widened by one bit so the +1 cannot wrap at the coordinate limit
    near   = head_valid &&
             {1'b0, cand_x} + 9'd1 >= {1'b0, head_x} && {1'b0, head_x} + 9'd1 >= {1'b0, cand_x} &&
             {1'b0, cand_y} + 9'd1 >= {1'b0, head_y} && {1'b0, head_y} + 9'd1 >= {1'b0, cand_y};
    slot   = 1'b0;
    for (int i = 0; i < MAX_OBS; i++)
      slot |= slots[i].valid && slots[i].x == cand_x && slots[i].y == cand_y;
    hit = border || apple || near || slot;
  end
endmodule

// File: rtl/obstacle_field.sv
// obstacle_field: stores up to MAX_OBS obstacle cells, adding one vetted random
// candidate per request, and answers the pixel-scan query combinationally.
module obstacle_field
  import obstacle_pkg::*;
#(
  parameter int GRID_W         = 16,
  parameter int GRID_H         = 16,
  parameter int COORD_W        = 4,
  parameter int MAX_LENGTH     = 80,
  parameter int MAX_OBS        = 8,
  parameter int MAX_TRIES      = 4,
  parameter bit REPLACE_OLDEST = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   nRst,
  input  logic                                   sync_reset,
  input  logic                                   enable,
  input  logic                                   add_req,
  input  logic [COORD_W-1:0]                     randX,
  input  logic [COORD_W-1:0]                     randY,
  input  logic [COORD_W-1:0]                     appleX,
  input  logic [COORD_W-1:0]                     appleY,
  input  logic [MAX_LENGTH-1:0][2*COORD_W-1:0]   body,
  input  logic [7:0]                             curr_length,
  input  logic [COORD_W-1:0]                     x,
  input  logic [COORD_W-1:0]                     y,
  output logic                                   obstacle,
  output logic [$clog2(MAX_OBS+1)-1:0]           obs_count,
  output logic                                   busy,
  output logic                                   add_done,
  output logic                                   add_fail
);
  localparam int CNT_W = $clog2(MAX_OBS + 1);
  localparam int PTR_W = MAX_OBS > 1 ? $clog2(MAX_OBS) : 1;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int IDX_W = MAX_LENGTH > 1 ? $clog2(MAX_LENGTH) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [COORD_W-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic               done_q, done_d, fail_q, fail_d;
  obs_slot_t          slots_q [MAX_OBS];
  obs_slot_t          slots_d [MAX_OBS];
  logic               static_hit, retry, full, obs_hit;
  coord_t             chk_x, chk_y, apple_x, apple_y, head_x, head_y;
  int                 scan_len;

  assign chk_x   = coord_t'(randX);
  assign chk_y   = coord_t'(randY);
  assign apple_x = coord_t'(appleX);
  assign apple_y = coord_t'(appleY);
  assign head_x  = coord_t'(body[0][2*COORD_W-1:COORD_W]);
  assign head_y  = coord_t'(body[0][COORD_W-1:0]);
  assign full    = int'(cnt_q) == MAX_OBS;

  obstacle_candidate_check #(.GRID_W(GRID_W), .GRID_H(GRID_H), .MAX_OBS(MAX_OBS)) u_check (
    .cand_x    (chk_x),
    .cand_y    (chk_y),
    .apple_x   (apple_x),
    .apple_y   (apple_y),
    .head_x    (head_x),
    .head_y    (head_y),
    .head_valid(curr_length != 8'd0),
    .slots     (slots_q),
    .hit       (static_hit)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tries_d  = tries_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    slots_d  = slots_q;
    done_d   = 1'b0;
    fail_d   = 1'b0;
    retry    = 1'b0;
    scan_len = int'(curr_length) > MAX_LENGTH ? MAX_LENGTH : int'(curr_length);
    if (sync_reset) begin
      state_d  = IDLE;
      idx_d    = '0;
      tries_d  = '0;
      cnt_d    = '0;
      wr_ptr_d = '0;
      for (int i = 0; i < MAX_OBS; i++) slots_d[i].valid = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (add_req && enable) begin
          tries_d = '0;
          if (full && !REPLACE_OLDEST) fail_d = 1'b1;
          else state_d = CAPTURE;
        end
        CAPTURE: begin
          cand_x_d = randX;
          cand_y_d = randY;
          idx_d    = '0;
          if (static_hit) retry = 1'b1;
          else state_d = scan_len == 0 ? COMMIT : SCAN;
        end
        SCAN:
          if (body[idx_q] == {cand_x_q, cand_y_q}) retry = 1'b1;
          else if (int'(idx_q) + 1 >= scan_len) state_d = COMMIT;
          else idx_d = idx_q + 1'b1;
        COMMIT: begin
          slots_d[wr_ptr_q] = '{valid: 1'b1, x: coord_t'(cand_x_q), y: coord_t'(cand_y_q)};
          wr_ptr_d = int'(wr_ptr_q) == MAX_OBS - 1 ? '0 : wr_ptr_q + 1'b1;
          cnt_d    = full ? cnt_q : cnt_q + 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (retry) begin
        tries_d = tries_q + 1'b1;
        fail_d  = int'(tries_q) + 1 >= MAX_TRIES;
        state_d = fail_d ? IDLE : CAPTURE;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tries_q  <= '0;
      cand_x_q <= '0;
      cand_y_q <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      for (int i = 0; i < MAX_OBS; i++) slots_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tries_q  <= tries_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      slots_q  <= slots_d;
    end

  always_comb begin
    obs_hit = 1'b0;
    for (int i = 0; i < MAX_OBS; i++)
      obs_hit |= slots_q[i].valid && slots_q[i].x == coord_t'(x) && slots_q[i].y == coord_t'(y);
  end

  assign obstacle  = enable && obs_hit;
  assign obs_count = cnt_q;
  assign busy      = state_q != IDLE;
  assign add_done  = done_q;
  assign add_fail  = fail_q;
endmodule

// File: tb/tb_obstacle_field.sv
// tb_obstacle_field: scoreboard bench driving a replacing and a rejecting instance in lockstep.
module tb_obstacle_field;
  localparam int CW = 4, ML = 80, NO = 8;

  logic clk = 0, nRst = 0, sync_reset = 0, enable = 0, add_req = 0;
  logic [CW-1:0] randX = 0, randY = 0, appleX = 4'd9, appleY = 4'd9, x = 0, y = 0;
  logic [ML-1:0][2*CW-1:0] body;
  logic [7:0] curr_length = 0;
  logic obs_r, obs_k, busy_r, busy_k, done_r, done_k, fail_r, fail_k;
  logic [3:0] cnt_r, cnt_k;
  int cyc = 0, checks = 0, failures = 0;

  typedef struct {logic ok; int at;} exp_t;
  exp_t q_r[$], q_k[$];
  exp_t er, ek;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  obstacle_field #(.REPLACE_OLDEST(1'b1)) dut_r (
    .clk(clk), .nRst(nRst), .sync_reset(sync_reset), .enable(enable), .add_req(add_req),
    .randX(randX), .randY(randY), .appleX(appleX), .appleY(appleY), .body(body),
    .curr_length(curr_length), .x(x), .y(y), .obstacle(obs_r), .obs_count(cnt_r),
    .busy(busy_r), .add_done(done_r), .add_fail(fail_r));

  obstacle_field #(.REPLACE_OLDEST(1'b0)) dut_k (
    .clk(clk), .nRst(nRst), .sync_reset(sync_reset), .enable(enable), .add_req(add_req),
    .randX(randX), .randY(randY), .appleX(appleX), .appleY(appleY), .body(body),
    .curr_length(curr_length), .x(x), .y(y), .obstacle(obs_k), .obs_count(cnt_k),
    .busy(busy_k), .add_done(done_k), .add_fail(fail_k));

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) if (nRst && (done_r || fail_r)) begin
    if (q_r.size() == 0) chk("r_unexpected_pulse", 1, 0);
    else begin
      er = q_r.pop_front();
      chk("r_outcome", 32'(done_r), 32'(er.ok));
      chk("r_latency", cyc, er.at);
    end
  end

  always @(negedge clk) if (nRst && (done_k || fail_k)) begin
    if (q_k.size() == 0) chk("k_unexpected_pulse", 1, 0);
    else begin
      ek = q_k.pop_front();
      chk("k_outcome", 32'(done_k), 32'(ek.ok));
      chk("k_latency", cyc, ek.at);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [CW-1:0] rx, input logic [CW-1:0] ry,
                     input int lat_r, input logic ok_r, input int lat_k, input logic ok_k);
    randX = rx;
    randY = ry;
    add_req = 1;
    if (lat_r > 0) q_r.push_back('{ok_r, cyc + lat_r});
    if (lat_k > 0) q_k.push_back('{ok_k, cyc + lat_k});
    step();
    add_req = 0;
  endtask

  task automatic settle();
    int n = 0;
    while ((q_r.size() != 0 || q_k.size() != 0 || busy_r || busy_k) && n < 200) begin
      step();
      n++;
    end
    chk("drain", q_r.size() + q_k.size(), 0);
    step();
  endtask

  task automatic probe(input string tag, input logic [CW-1:0] qx, input logic [CW-1:0] qy,
                       input logic exp_r, input logic exp_k);
    x = qx;
    y = qy;
    #1;
    chk({tag, "_r"}, 32'(obs_r), 32'(exp_r));
    chk({tag, "_k"}, 32'(obs_k), 32'(exp_k));
  endtask

  initial begin
    body = '0;
    body[0] = 8'h55;
    body[1] = 8'h56;
    body[2] = 8'h57;
    #2;
    chk("rst_obs", 32'(obs_r | obs_k), 0);
    chk("rst_cnt", 32'(cnt_r | cnt_k), 0);
    chk("rst_busy", 32'(busy_r | busy_k), 0);
    chk("rst_pulse", 32'(done_r | done_k | fail_r | fail_k), 0);
    step();
    nRst = 1;
    step();

    enable = 1;
    curr_length = 3;
    req(4'd3, 4'd10, 6, 1'b1, 6, 1'b1);
    settle();
    chk("add1_cnt_r", 32'(cnt_r), 1);
    chk("add1_cnt_k", 32'(cnt_k), 1);
    probe("add1_cell", 4'd3, 4'd10, 1'b1, 1'b1);

    req(4'd0, 4'd4, 5, 1'b0, 5, 1'b0);
    settle();
    chk("border_cnt_r", 32'(cnt_r), 1);
    chk("border_cnt_k", 32'(cnt_k), 1);

    req(4'd5, 4'd7, 10, 1'b1, 10, 1'b1);
    step();
    step();
    randX = 4'd12;
    randY = 4'd2;
    settle();
    chk("retry_cnt_r", 32'(cnt_r), 2);
    probe("retry_cell", 4'd12, 4'd2, 1'b1, 1'b1);
    probe("retry_cand0", 4'd5, 4'd7, 1'b0, 1'b0);

    enable = 0;
    probe("mask_a", 4'd3, 4'd10, 1'b0, 1'b0);
    probe("mask_b", 4'd12, 4'd2, 1'b0, 1'b0);
    req(4'd2, 4'd12, 0, 1'b0, 0, 1'b0);
    repeat (8) step();
    chk("mask_busy", 32'(busy_r | busy_k), 0);
    chk("mask_cnt", 32'(cnt_r), 2);
    enable = 1;
    probe("unmask_a", 4'd3, 4'd10, 1'b1, 1'b1);
    probe("unmask_b", 4'd12, 4'd2, 1'b1, 1'b1);

    for (int i = 0; i < 6; i++) begin
      req(4'(2 + i), 4'd12, 6, 1'b1, 6, 1'b1);
      settle();
    end
    chk("fill_cnt_r", 32'(cnt_r), NO);
    chk("fill_cnt_k", 32'(cnt_k), NO);

    req(4'd7, 4'd3, 6, 1'b1, 1, 1'b0);
    settle();
    chk("full_cnt_r", 32'(cnt_r), NO);
    chk("full_cnt_k", 32'(cnt_k), NO);
    probe("full_oldest", 4'd3, 4'd10, 1'b0, 1'b1);
    probe("full_new", 4'd7, 4'd3, 1'b1, 1'b0);
    probe("full_keep", 4'd4, 4'd12, 1'b1, 1'b1);

    req(4'd10, 4'd4, 0, 1'b0, 1, 1'b0);
    step();
    chk("sr_busy_before", 32'(busy_r), 1);
    sync_reset = 1;
    add_req = 1;
    step();
    sync_reset = 0;
    add_req = 0;
    chk("sr_busy_r", 32'(busy_r), 0);
    chk("sr_busy_k", 32'(busy_k), 0);
    chk("sr_cnt_r", 32'(cnt_r), 0);
    chk("sr_cnt_k", 32'(cnt_k), 0);
    probe("sr_cleared", 4'd4, 4'd12, 1'b0, 1'b0);
    repeat (8) step();
    settle();

    req(4'd4, 4'd13, 6, 1'b1, 6, 1'b1);
    settle();
    chk("post_sr_cnt_r", 32'(cnt_r), 1);
    chk("post_sr_cnt_k", 32'(cnt_k), 1);
    probe("post_sr_cell", 4'd4, 4'd13, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
